// File: rtl/adpll_pkg.sv
// adpll_pkg
// Shared types and constants for the ADPLL loop blocks.
//   state_t  : handshake state of the phase error counter (COUNT / HOLD)
//   count_t  : signed loop count at the default loop width
//   sat_max  : largest two's complement value representable in `width` bits
//   sat_min  : smallest two's complement value representable in `width` bits
package adpll_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 20;

  typedef logic signed [DEFAULT_WIDTH-1:0] count_t;

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sat_accum.sv
// sat_accum
// Combinational signed saturating add of a -1/0/+1 step to an accumulator.
//   acc   : current accumulator value (two's complement, WIDTH bits)
//   delta : step, signed 2-bit (-1, 0 or +1)
//   sum   : acc + delta, clamped to the WIDTH-bit signed range
//   clamp : high when the true sum fell outside the range and was clamped
module sat_accum
  import adpll_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic signed [WIDTH-1:0] acc,
  input  logic signed [1:0]       delta,
  output logic signed [WIDTH-1:0] sum,
  output logic                    clamp
);

  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] wide_sum;

  always_comb begin
    // One guard bit is enough for a unit step: overflow shows up as the
    // guard bit disagreeing with the result's sign bit.
    wide_sum = {acc[WIDTH-1], acc} + {{(WIDTH-1){delta[1]}}, delta};
    clamp    = wide_sum[WIDTH] ^ wide_sum[WIDTH-1];
    if (clamp) begin
      sum = wide_sum[WIDTH] ? MIN_V : MAX_V;
    end else begin
      sum = wide_sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/phase_error_counter.sv
// phase_error_counter
// Accumulates up/down detector strobes over a fixed window, freezes the count
// at window end and hands it to the save stage with a trigger/cleared
// handshake. Events arriving while waiting for the clear go to a shadow
// accumulator that seeds the next window.
//   fpga_clk_i        : clock, rising edge
//   reset_i           : asynchronous active-high reset
//   up_i / dn_i       : +1 / -1 event strobes
//   counter_cleared_i : save stage has captured the value (pulse)
//   counter_val_o     : registered signed count
//   trigger_o         : one-cycle pulse, value is frozen and must be saved
//   busy_o            : waiting for the clear (HOLD)
//   overrun_o         : sticky, a window ended while still in HOLD
//   sat_o             : sticky, counter or shadow clamped
module phase_error_counter
  import adpll_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int WINDOW = 8
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    up_i,
  input  logic                    dn_i,
  input  logic                    counter_cleared_i,
  output logic signed [WIDTH-1:0] counter_val_o,
  output logic                    trigger_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    sat_o
);

  localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);

  state_t                  state_reg,   state_next;
  logic signed [WIDTH-1:0] counter_reg, counter_next;
  logic signed [WIDTH-1:0] shadow_reg,  shadow_next;
  logic [WCNT_W-1:0]       wcnt_reg,    wcnt_next;
  logic                    trigger_reg, trigger_next;
  logic                    overrun_reg, overrun_next;
  logic                    sat_reg,     sat_next;

  logic signed [1:0]       delta;
  logic                    window_end;
  logic signed [WIDTH-1:0] cnt_sum, sh_sum;
  logic                    cnt_clamp, sh_clamp;

  // Simultaneous strobes cancel.
  always_comb begin
    delta = 2'sb00;
    if (up_i && !dn_i) begin
      delta = 2'sb01;
    end else if (dn_i && !up_i) begin
      delta = 2'sb11;
    end
  end

  assign window_end = (wcnt_reg == WCNT_LAST);

  sat_accum #(.WIDTH(WIDTH)) u_counter_acc (
    .acc   (counter_reg),
    .delta (delta),
    .sum   (cnt_sum),
    .clamp (cnt_clamp)
  );

  sat_accum #(.WIDTH(WIDTH)) u_shadow_acc (
    .acc   (shadow_reg),
    .delta (delta),
    .sum   (sh_sum),
    .clamp (sh_clamp)
  );

  // State register (all sequential state of the block).
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg   <= COUNT;
      counter_reg <= '0;
      shadow_reg  <= '0;
      wcnt_reg    <= '0;
      trigger_reg <= 1'b0;
      overrun_reg <= 1'b0;
      sat_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      shadow_reg  <= shadow_next;
      wcnt_reg    <= wcnt_next;
      trigger_reg <= trigger_next;
      overrun_reg <= overrun_next;
      sat_reg     <= sat_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    shadow_next  = shadow_reg;
    trigger_next = 1'b0;
    overrun_next = overrun_reg;
    sat_next     = sat_reg;

    // The window timer free-runs regardless of the handshake so the trigger
    // cadence stays locked to the window even after an overrun.
    wcnt_next = window_end ? '0 : wcnt_reg + 1'b1;

    case (state_reg)
      COUNT: begin
        counter_next = cnt_sum;
        sat_next     = sat_reg | cnt_clamp;
        if (window_end) begin
          state_next   = HOLD;
          trigger_next = 1'b1;
        end
      end
      HOLD: begin
        sat_next = sat_reg | sh_clamp;
        if (window_end) begin
          overrun_next = 1'b1;
        end
        if (counter_cleared_i) begin
          // The new window starts from everything seen during the handshake,
          // including this cycle's event.
          counter_next = sh_sum;
          shadow_next  = '0;
          state_next   = COUNT;
        end else begin
          shadow_next = sh_sum;
        end
      end
      default: begin
        state_next = COUNT;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    counter_val_o = counter_reg;
    trigger_o     = trigger_reg;
    busy_o        = (state_reg == HOLD);
    overrun_o     = overrun_reg;
    sat_o         = sat_reg;
  end

endmodule

// File: doc/phase_error_counter.md
# phase_error_counter

Produces the signed count that the save-and-clear stage samples, and drives the `trigger`/`cleared` handshake from the other end. Sits between the phase/frequency detector strobes and the save stage in the ADPLL loop:
- Accumulates up/down event strobes over a fixed window of `fpga_clk_i` cycles.
- At window end, freezes the count and pulses `trigger_o`.
- Restarts from zero when the save stage answers with `counter_cleared_i`.
- Events arriving during the handshake are held in a shadow accumulator, so none are lost.

## Interface
- `WIDTH`, 20, width of the signed count (two's complement).
- `WINDOW`, 8, window length in `fpga_clk_i` cycles; must be ≥ 4.
- `fpga_clk_i`  input  1  system clock; all logic on the rising edge.
- `reset_i`  input  1  reset; asynchronous, active-high.
- `up_i`  input  1  +1 event strobe, one per cycle maximum.
- `dn_i`  input  1  −1 event strobe, one per cycle maximum.
- `counter_cleared_i`  input  1  save stage has captured the value; one-cycle pulse.
- `counter_val_o`  output  WIDTH  signed count, registered.
- `trigger_o`  output  1  one-cycle pulse; the value is stable and must be saved.
- `busy_o`  output  1  high while in HOLD (waiting for clear).
- `overrun_o`  output  1  sticky; a window expired while still in HOLD.
- `sat_o`  output  1  sticky; a counter or shadow saturated.

## Operation
- **Reset state:** `counter_val_o`=0, shadow=0, window count `wcnt`=0, state COUNT. `trigger_o`, `busy_o`, `overrun_o`, `sat_o` are all 0. Async assert and synchronous-edge release.
- **Event delta per cycle:** `up_i` only gives +1, `dn_i` only gives −1, both or neither gives 0.
- **Window timer:** `wcnt` runs 0..WINDOW-1, wraps, and free-runs in every state.
- **COUNT state:**
  - `counter_val_o` += delta each cycle.
  - On the cycle `wcnt`==WINDOW-1, that cycle's delta is still applied. The next edge sets `trigger_o`=1, state=HOLD, `busy_o`=1.
  - `counter_cleared_i` in COUNT is ignored.
- **HOLD state:**
  - `counter_val_o` is frozen.
  - Shadow += delta each cycle.
  - On the cycle `counter_cleared_i`=1: `counter_val_o` ← shadow + delta that cycle; shadow ← 0; state ← COUNT; `busy_o` ← 0.
- **Overrun:** if `wcnt` reaches WINDOW-1 while in HOLD:
  - `overrun_o` ← 1 and stays set until reset.
  - No second trigger is issued.
  - The next trigger occurs at the first window end after returning to COUNT.
- **Saturation:** both `counter_val_o` and shadow clamp at +2^(WIDTH-1)−1 and −2^(WIDTH-1). Any clamp sets `sat_o` (sticky until reset). A clamped value recovers normally on the opposite delta.
- **Reset mid-handshake:** all state returns to reset values. A `counter_cleared_i` arriving after reset release is ignored, because the state is COUNT.

## Timing
- Window-end cycle to `trigger_o`=1: 1 edge. `trigger_o` is high for exactly 1 cycle.
- While `busy_o`=1, `counter_val_o` equals the value at the trigger edge.
- Earliest legal `counter_cleared_i`: the cycle `trigger_o` is high. The save stage's response lands 1–2 cycles later.
- `counter_cleared_i` to restarted count visible: 1 edge.
- Trigger period in steady state: exactly WINDOW cycles, provided the clear arrives within WINDOW−1 cycles of the trigger.

## Structure
- **Shared package `adpll_pkg`:**
  - `state_t` enum {COUNT, HOLD}.
  - `count_t` for signed [WIDTH-1:0].
  - SAT_MAX/SAT_MIN constant functions of WIDTH.
- **Sub-module `sat_accum`:** signed saturating add of a −1/0/+1 delta with a clamp flag. Instantiated twice, once for the counter and once for the shadow.
- **Top level holds:** the FSM, window timer, and sticky flags.

## Test plan
- **Reset, then up counting:** reset released, `up_i`=1 continuously → `trigger_o` pulses every 8 cycles with `counter_val_o`=8. Clear returned 2 cycles later → next frozen value is 8 and no event is lost.
- **Mixed strobes:** 3 up, 2 simultaneous up+dn, 3 dn within one window → frozen value −0 = 0. Then 5 dn → frozen value −5 (0xFFFFB).
- **Events during HOLD:** 2 up strobes after the trigger, `counter_cleared_i` on the 3rd HOLD cycle together with `up_i` → `counter_val_o`=3 the next cycle.
- **Overrun:** withhold `counter_cleared_i` for 10 cycles → `overrun_o`=1, no second `trigger_o`. After the clear, the next trigger arrives at the following window end.
- **Saturation:** WIDTH=4, WINDOW=16, `up_i` held → value clamps at 7, `sat_o`=1. Then `dn_i` → 6.
- **Reset mid-HOLD:** assert `reset_i` asynchronously between edges while `busy_o`=1 → all outputs 0 immediately. A `counter_cleared_i` pulse after release leaves the count unaffected.
